// File: rtl/board_result_ctrl.sv
// Board-level controller: debounced start key, accelerator start/done handshake with
// timeout, sequential signed argmax over class scores, decimal 7-segment and one-hot LED result.
module board_result_ctrl #(
    parameter int CLASSES    = 10,
    parameter int SCORE_W    = 16,
    parameter int IMAGES     = 10,
    parameter int SEL_W      = 4,
    parameter int HEX_DIGITS = 2,
    parameter int DEBOUNCE   = 16,
    parameter int TIMEOUT    = 1048576
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        key_start_n,
    input  logic [SEL_W-1:0]            sw_image,
    output logic                        acc_start,
    output logic [$clog2(IMAGES)-1:0]   acc_image_num,
    input  logic                        acc_ready,
    input  logic [CLASSES*SCORE_W-1:0]  acc_scores,
    output logic [HEX_DIGITS*7-1:0]     hex,
    output logic [CLASSES-1:0]          ledr,
    output logic                        busy,
    output logic                        timeout_err
);
    localparam int IMG_W = $clog2(IMAGES);
    localparam int IDX_W = $clog2(CLASSES);
    localparam int DB_W  = $clog2(DEBOUNCE);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE, S_SCAN, S_SHOW
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    state_t                    state_q, state_d;
    logic                      sync1_q, sync1_d, sync2_q, sync2_d;
    logic                      filt_q, filt_d, press_q, press_d;
    logic [DB_W-1:0]           db_cnt_q, db_cnt_d;
    logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic [IDX_W-1:0]          k_q, k_d, best_idx_q, best_idx_d;
    logic signed [SCORE_W-1:0] best_val_q, best_val_d;
    logic signed [SCORE_W-1:0] scores_q [CLASSES];
    logic signed [SCORE_W-1:0] scores_d [CLASSES];
    logic                      acc_start_q, acc_start_d, busy_q, busy_d;
    logic                      tmo_err_q, tmo_err_d;
    logic [IMG_W-1:0]          image_q, image_d, image_clamped;
    logic [HEX_DIGITS*7-1:0]   hex_q, hex_d;
    logic [CLASSES-1:0]        ledr_q, ledr_d;
    logic [6:0]                best_dec;
    logic [3:0]                tens, units;
    logic                      tmo_hit;

    assign image_clamped = (int'(sw_image) > IMAGES - 1) ? IMG_W'(IMAGES - 1) : IMG_W'(sw_image);
    assign best_dec      = 7'(best_idx_q);
    assign tens          = 4'(best_dec / 7'd10);
    assign units         = 4'(best_dec % 7'd10);
    assign tmo_hit       = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        sync1_d    = key_start_n;
        sync2_d    = sync1_q;
        filt_d     = filt_q;
        db_cnt_d   = '0;
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmo_err_d  = tmo_err_q;
        image_d    = image_q;
        k_d        = k_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        scores_d   = scores_q;
        hex_d      = hex_q;
        ledr_d     = ledr_q;

        // The filtered level only follows after DEBOUNCE consecutive differing samples.
        if (sync2_q != filt_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE - 1)) filt_d = sync2_q;
            else                                 db_cnt_d = db_cnt_q + 1'b1;
        end
        press_d = filt_q & ~filt_d;

        unique case (state_q)
            S_IDLE: begin
                if (press_q) begin
                    state_d   = S_START;
                    image_d   = image_clamped;
                    tmo_cnt_d = '0;
                    tmo_err_d = 1'b0;
                end
            end
            S_START: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tmo_hit) begin
                    state_d   = S_SHOW;
                    tmo_err_d = 1'b1;
                end else if (!acc_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // A done arriving on the timeout cycle still counts as a result.
                if (acc_ready) begin
                    for (int k = 0; k < CLASSES; k++)
                        scores_d[k] = acc_scores[k*SCORE_W +: SCORE_W];
                    k_d     = '0;
                    state_d = S_SCAN;
                end else if (tmo_hit) begin
                    state_d   = S_SHOW;
                    tmo_err_d = 1'b1;
                end
            end
            S_SCAN: begin
                if (k_q == '0 || scores_q[k_q] > best_val_q) begin
                    best_val_d = scores_q[k_q];
                    best_idx_d = k_q;
                end
                if (k_q == IDX_W'(CLASSES - 1)) state_d = S_SHOW;
                else                            k_d = k_q + 1'b1;
            end
            S_SHOW: begin
                state_d = S_IDLE;
                if (tmo_err_q) begin
                    ledr_d     = '0;
                    hex_d      = {HEX_DIGITS{SEG_BLANK}};
                    hex_d[6:0] = SEG_E;
                end else begin
                    ledr_d = {{(CLASSES-1){1'b0}}, 1'b1} << best_idx_q;
                    for (int i = 0; i < HEX_DIGITS; i++) begin
                        if (i == 0) hex_d[i*7 +: 7] = seg7(units);
                        else        hex_d[i*7 +: 7] = (tens == 4'd0) ? SEG_BLANK : seg7(tens);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        acc_start_d = (state_d == S_START);
        busy_d      = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            filt_q      <= 1'b1;
            press_q     <= 1'b0;
            db_cnt_q    <= '0;
            tmo_cnt_q   <= '0;
            k_q         <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            acc_start_q <= 1'b0;
            busy_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
            image_q     <= '0;
            hex_q       <= {HEX_DIGITS{SEG_BLANK}};
            ledr_q      <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_q      <= filt_d;
            press_q     <= press_d;
            db_cnt_q    <= db_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            k_q         <= k_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            acc_start_q <= acc_start_d;
            busy_q      <= busy_d;
            tmo_err_q   <= tmo_err_d;
            image_q     <= image_d;
            hex_q       <= hex_d;
            ledr_q      <= ledr_d;
        end
    end

    // NOTE: the score buffer is left unreset; it is always written before SCAN reads it.
    always_ff @(posedge clk) scores_q <= scores_d;

    assign acc_start     = acc_start_q;
    assign acc_image_num = image_q;
    assign hex           = hex_q;
    assign ledr          = ledr_q;
    assign busy          = busy_q;
    assign timeout_err   = tmo_err_q;
endmodule

// File: tb/tb_board_result_ctrl.sv
// Randomised self-checking bench for board_result_ctrl: a 10-class and a 12-class instance
// against a reference argmax / decimal-display model.
`timescale 1ns/1ps
module tb_board_result_ctrl;
    localparam int DB  = 4;
    localparam int TMO = 200;
    localparam int CA  = 10;
    localparam int CB  = 12;
    localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, key_a, key_b, ready_a, ready_b;
    logic [3:0]        sw_a, sw_b, img_a, img_b;
    logic [CA*16-1:0]  scores_a;
    logic [CB*16-1:0]  scores_b;
    logic              start_a, start_b, busy_a, busy_b, terr_a, terr_b;
    logic [13:0]       hex_a, hex_b;
    logic [CA-1:0]     ledr_a;
    logic [CB-1:0]     ledr_b;

    board_result_ctrl #(.CLASSES(CA), .SCORE_W(16), .IMAGES(10), .SEL_W(4), .HEX_DIGITS(2),
        .DEBOUNCE(DB), .TIMEOUT(TMO)) dut_a (
        .clk(clk), .reset_n(reset_n), .key_start_n(key_a), .sw_image(sw_a),
        .acc_start(start_a), .acc_image_num(img_a), .acc_ready(ready_a), .acc_scores(scores_a),
        .hex(hex_a), .ledr(ledr_a), .busy(busy_a), .timeout_err(terr_a));

    board_result_ctrl #(.CLASSES(CB), .SCORE_W(16), .IMAGES(10), .SEL_W(4), .HEX_DIGITS(2),
        .DEBOUNCE(DB), .TIMEOUT(TMO)) dut_b (
        .clk(clk), .reset_n(reset_n), .key_start_n(key_b), .sw_image(sw_b),
        .acc_start(start_b), .acc_image_num(img_b), .acc_ready(ready_b), .acc_scores(scores_b),
        .hex(hex_b), .ledr(ledr_b), .busy(busy_b), .timeout_err(terr_b));

    int checks = 0;
    int failures = 0;
    int start_cnt_a = 0;
    int start_cnt_b = 0;
    logic signed [15:0] sc_a [CA];
    logic signed [15:0] sc_b [CB];

    always @(negedge clk) begin
        if (start_a) start_cnt_a++;
        if (start_b) start_cnt_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: first index holding the maximum signed score.
    function automatic int argmax_a();
        int best = 0;
        for (int k = 1; k < CA; k++) if (sc_a[k] > sc_a[best]) best = k;
        return best;
    endfunction

    function automatic logic [13:0] exp_hex(input int w);
        logic [6:0] d1;
        d1 = (w / 10 == 0) ? 7'h7F : SEG_TAB[w / 10];
        return {d1, SEG_TAB[w % 10]};
    endfunction

    function automatic logic [CA-1:0] exp_led_a(input int w);
        logic [CA-1:0] v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Press key, play the accelerator (or hang it), measure latencies.
    task automatic run_txn_a(input logic [3:0] sw, input bit hang, output int start_lat,
                             output int done_lat, output int starts, output logic [3:0] img,
                             output logic err_at_start);
        int s0;
        s0 = start_cnt_a;
        sw_a = sw; key_a = 1'b0; start_lat = -1; done_lat = -1;
        for (int n = 1; n <= 4*DB + 20; n++) begin
            tick();
            if (start_a) begin start_lat = n; break; end
        end
        img = img_a; err_at_start = terr_a;
        key_a = 1'b1;
        if (start_lat > 0) begin
            if (hang) begin
                for (int n = 1; n <= TMO + 20; n++) begin
                    tick();
                    if (!busy_a) begin done_lat = n; break; end
                end
            end else begin
                tick(); tick();
                ready_a = 1'b0;
                repeat ($urandom_range(1, 5)) tick();
                for (int k = 0; k < CA; k++) scores_a[k*16 +: 16] = sc_a[k];
                ready_a = 1'b1;
                for (int n = 1; n <= CA + 20; n++) begin
                    tick();
                    if (!busy_a) begin done_lat = n; break; end
                end
            end
        end
        repeat (DB + 4) tick();
        starts = start_cnt_a - s0;
    endtask

    task automatic run_txn_b(input int abort_at, output int start_lat, output int done_lat);
        key_b = 1'b0; start_lat = -1; done_lat = -1;
        for (int n = 1; n <= 4*DB + 20; n++) begin
            tick();
            if (start_b) begin start_lat = n; break; end
        end
        key_b = 1'b1;
        if (start_lat > 0) begin
            tick(); tick();
            ready_b = 1'b0;
            repeat (3) tick();
            for (int k = 0; k < CB; k++) scores_b[k*16 +: 16] = sc_b[k];
            ready_b = 1'b1;
            if (abort_at > 0) repeat (abort_at) tick();
            else for (int n = 1; n <= CB + 20; n++) begin
                tick();
                if (!busy_b) begin done_lat = n; break; end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; key_a = 1'b1; key_b = 1'b1; sw_a = '0; sw_b = '0;
        ready_a = 1'b1; ready_b = 1'b1; scores_a = '0; scores_b = '0;
        repeat (3) tick();
        checks++; if (start_a !== 1'b0) begin failures++; $display("FAIL reset_start: got %b want 0", start_a); end
        checks++; if (img_a !== 4'd0) begin failures++; $display("FAIL reset_img: got %0d want 0", img_a); end
        checks++; if (hex_a !== 14'h3FFF) begin failures++; $display("FAIL reset_hex: got %h want 3fff", hex_a); end
        checks++; if (ledr_a !== '0) begin failures++; $display("FAIL reset_ledr: got %b want 0", ledr_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if (terr_a !== 1'b0) begin failures++; $display("FAIL reset_terr: got %b want 0", terr_a); end
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int sl, dl, st; logic [3:0] img; logic e0;
        for (int k = 0; k < CA; k++) sc_a[k] = 16'(k * 10);
        run_txn_a(4'd3, 1'b0, sl, dl, st, img, e0);
        checks++; if (sl != DB + 3) begin failures++; $display("FAIL basic_start_latency: got %0d want %0d", sl, DB + 3); end
        checks++; if (st != 1) begin failures++; $display("FAIL basic_start_count: got %0d want 1", st); end
        checks++; if (img !== 4'd3) begin failures++; $display("FAIL basic_image: got %0d want 3", img); end
        checks++; if (dl != CA + 2) begin failures++; $display("FAIL basic_done_latency: got %0d want %0d", dl, CA + 2); end
        checks++; if (ledr_a !== 10'b1000000000) begin failures++; $display("FAIL basic_ledr: got %b want 1000000000", ledr_a); end
        checks++; if (hex_a[6:0] !== 7'b0010000) begin failures++; $display("FAIL basic_hex0: got %b want 0010000", hex_a[6:0]); end
        checks++; if (hex_a[13:7] !== 7'h7F) begin failures++; $display("FAIL basic_hex1: got %b want 1111111", hex_a[13:7]); end
        checks++; if (terr_a !== 1'b0) begin failures++; $display("FAIL basic_terr: got %b want 0", terr_a); end
    endtask

    task automatic test_neg_ties();
        int sl, dl, st; logic [3:0] img; logic e0;
        for (int k = 0; k < CA; k++) sc_a[k] = -16'sd5;
        sc_a[2] = -16'sd1; sc_a[4] = 16'sd100; sc_a[7] = 16'sd100;
        run_txn_a(4'd15, 1'b0, sl, dl, st, img, e0);
        checks++; if (img !== 4'd9) begin failures++; $display("FAIL clamp_image: got %0d want 9", img); end
        checks++; if (ledr_a !== 10'b0000010000) begin failures++; $display("FAIL tie_ledr: got %b want 0000010000", ledr_a); end
        checks++; if (hex_a !== {7'h7F, 7'b0011001}) begin failures++; $display("FAIL tie_hex: got %h want %h", hex_a, {7'h7F, 7'b0011001}); end
        for (int k = 0; k < CA; k++) sc_a[k] = -16'sd5;
        sc_a[2] = -16'sd1;
        run_txn_a(4'd0, 1'b0, sl, dl, st, img, e0);
        checks++; if (ledr_a !== 10'b0000000100) begin failures++; $display("FAIL neg_ledr: got %b want 0000000100", ledr_a); end
    endtask

    task automatic test_bounce();
        int s0, dl, w;
        s0 = start_cnt_a; sw_a = 4'd1;
        for (int p = 1; p < DB; p++) begin
            key_a = 1'b0; repeat (p) tick();
            key_a = 1'b1; repeat (DB + 3) tick();
        end
        checks++; if (start_cnt_a - s0 != 0) begin failures++; $display("FAIL bounce_short: got %0d starts want 0", start_cnt_a - s0); end
        key_a = 1'b0;
        for (int n = 0; n < 4*DB + 20 && !start_a; n++) tick();
        repeat (2) tick();
        key_a = 1'b1; tick(); key_a = 1'b0;
        ready_a = 1'b0;
        repeat (DB + 2) tick();
        key_a = 1'b1; repeat (DB + 4) tick();
        key_a = 1'b0; repeat (DB + 6) tick();
        key_a = 1'b1; repeat (DB + 4) tick();
        for (int k = 0; k < CA; k++) sc_a[k] = 16'($urandom);
        w = argmax_a();
        for (int k = 0; k < CA; k++) scores_a[k*16 +: 16] = sc_a[k];
        ready_a = 1'b1; dl = -1;
        for (int n = 1; n <= CA + 20; n++) begin
            tick();
            if (!busy_a) begin dl = n; break; end
        end
        repeat (DB + 4) tick();
        checks++; if (start_cnt_a - s0 != 1) begin failures++; $display("FAIL bounce_one_start: got %0d want 1", start_cnt_a - s0); end
        checks++; if (dl != CA + 2) begin failures++; $display("FAIL bounce_done_latency: got %0d want %0d", dl, CA + 2); end
        checks++; if (ledr_a !== exp_led_a(w)) begin failures++; $display("FAIL bounce_ledr: got %b want %b", ledr_a, exp_led_a(w)); end
        checks++; if (hex_a !== exp_hex(w)) begin failures++; $display("FAIL bounce_hex: got %h want %h", hex_a, exp_hex(w)); end
    endtask

    task automatic test_timeout();
        int sl, dl, st, w; logic [3:0] img; logic e0;
        run_txn_a(4'd5, 1'b1, sl, dl, st, img, e0);
        checks++; if (st != 1) begin failures++; $display("FAIL tmo_start_count: got %0d want 1", st); end
        checks++; if (dl < TMO || dl > TMO + 2) begin failures++; $display("FAIL tmo_latency: got %0d want %0d..%0d", dl, TMO, TMO + 2); end
        checks++; if (terr_a !== 1'b1) begin failures++; $display("FAIL tmo_flag: got %b want 1", terr_a); end
        checks++; if (hex_a !== {7'h7F, 7'b0000110}) begin failures++; $display("FAIL tmo_hex: got %h want %h", hex_a, {7'h7F, 7'b0000110}); end
        checks++; if (ledr_a !== '0) begin failures++; $display("FAIL tmo_ledr: got %b want 0", ledr_a); end
        for (int k = 0; k < CA; k++) sc_a[k] = 16'($urandom);
        w = argmax_a();
        run_txn_a(4'd2, 1'b0, sl, dl, st, img, e0);
        checks++; if (e0 !== 1'b0) begin failures++; $display("FAIL tmo_clear_at_start: got %b want 0", e0); end
        checks++; if (terr_a !== 1'b0) begin failures++; $display("FAIL tmo_after_ok: got %b want 0", terr_a); end
        checks++; if (ledr_a !== exp_led_a(w)) begin failures++; $display("FAIL tmo_recover_ledr: got %b want %b", ledr_a, exp_led_a(w)); end
    endtask

    task automatic test_random();
        int sl, dl, st, w; logic [3:0] img, sw, exp_img; logic e0;
        for (int t = 0; t < 6; t++) begin
            sw = 4'($urandom_range(0, 15));
            exp_img = (sw > 4'd9) ? 4'd9 : sw;
            for (int k = 0; k < CA; k++)
                sc_a[k] = (t % 2 == 0) ? 16'(int'($urandom_range(0, 6)) - 3) : 16'($urandom);
            w = argmax_a();
            run_txn_a(sw, 1'b0, sl, dl, st, img, e0);
            checks++; if (img !== exp_img) begin failures++; $display("FAIL rand_image[%0d]: got %0d want %0d", t, img, exp_img); end
            checks++; if (st != 1 || dl != CA + 2) begin failures++; $display("FAIL rand_handshake[%0d]: starts %0d latency %0d want 1 and %0d", t, st, dl, CA + 2); end
            checks++; if (ledr_a !== exp_led_a(w)) begin failures++; $display("FAIL rand_ledr[%0d]: got %b want %b", t, ledr_a, exp_led_a(w)); end
            checks++; if (hex_a !== exp_hex(w)) begin failures++; $display("FAIL rand_hex[%0d]: got %h want %h", t, hex_a, exp_hex(w)); end
        end
    endtask

    task automatic test_wide_and_abort();
        int sl, dl, s0;
        sw_b = 4'd7;
        for (int k = 0; k < CB; k++) sc_b[k] = 16'(int'($urandom_range(0, 2000)) - 1000);
        sc_b[11] = 16'sd2000;
        run_txn_b(0, sl, dl);
        checks++; if (dl != CB + 2) begin failures++; $display("FAIL wide_done_latency: got %0d want %0d", dl, CB + 2); end
        checks++; if (ledr_b !== 12'h800) begin failures++; $display("FAIL wide_ledr: got %h want 800", ledr_b); end
        checks++; if (hex_b !== {7'b1111001, 7'b1111001}) begin failures++; $display("FAIL wide_hex: got %h want %h", hex_b, {7'b1111001, 7'b1111001}); end
        repeat (DB + 4) tick();
        run_txn_b(4, sl, dl);
        checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL abort_in_scan: got busy %b want 1", busy_b); end
        reset_n = 1'b0;
        tick();
        checks++; if (start_b !== 1'b0 || img_b !== 4'd0) begin failures++; $display("FAIL abort_start_img: got %b/%0d want 0/0", start_b, img_b); end
        checks++; if (hex_b !== 14'h3FFF) begin failures++; $display("FAIL abort_hex: got %h want 3fff", hex_b); end
        checks++; if (ledr_b !== '0) begin failures++; $display("FAIL abort_ledr: got %h want 0", ledr_b); end
        checks++; if (busy_b !== 1'b0 || terr_b !== 1'b0) begin failures++; $display("FAIL abort_busy_terr: got %b/%b want 0/0", busy_b, terr_b); end
        reset_n = 1'b1;
        s0 = start_cnt_b;
        ready_b = 1'b0; repeat (3) tick();
        ready_b = 1'b1; repeat (CB + 4) tick();
        checks++; if (busy_b !== 1'b0 || start_cnt_b != s0) begin failures++; $display("FAIL idle_ignores_ready: got busy %b starts %0d want 0/0", busy_b, start_cnt_b - s0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_ties();
        test_bounce();
        test_timeout();
        test_random();
        test_wide_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
